falling_edge_generator: RTL and testbench
=========================================

// Module: falling_edge_generator
// PURPOSE
//   N-channel active-low pulse generator: the transmit side of the button/strobe interface.
//   Turns 1-cycle internal trigger requests into clean, glitch-free active-low pulses on
//   pulse_n, one pulse per accepted request.
//   Guaranteed minimum low time and recovery (high) time, so a 2-flop synchronizing
//   falling-edge detector on the far side sees exactly one falling edge per pulse.
//   Used for board loopback tests and for driving strobe lines between lab sub-blocks.
// PARAMETERS
//   N           7   number of independent channels
//   LOW_CYCLES  4   clk cycles pulse_n[i] is held low per pulse; must be >= 1
//   HIGH_CYCLES 2   minimum clk cycles pulse_n[i] is held high after each pulse; must be >= 1
// PORTS
//   clk      in   1  system clock; all logic on posedge
//   reset    in   1  asynchronous, active-high
//   trigger  in   N  per-channel request strobes, sampled on posedge, synchronous to clk
//   pulse_n  out  N  per-channel active-low pulse outputs, driven directly from flops
//   busy     out  N  per-channel flag: 1 when the channel is not IDLE (registered)
//   dropped  out  N  per-channel 1-cycle strobe: a request was lost to overflow (registered)
// BEHAVIOUR
//   Reset: pulse_n = all 1s, busy = 0, dropped = 0, every channel IDLE.
//     Each channel's pending flag and counter clear on reset.
//   Channels are fully independent; everything below applies per channel i.
//   Per-channel state: IDLE, ACTIVE, GAP.
//     Also per channel: pending flag (1 bit) and down-counter cnt.
//     cnt width = $clog2(max(LOW_CYCLES, HIGH_CYCLES) + 1).
//   IDLE:
//     trigger[i]=1 -> ACTIVE, cnt <= LOW_CYCLES-1.
//     pulse_n[i] goes low on the same clock edge (1-cycle latency from the trigger sample).
//   ACTIVE: pulse_n[i]=0.
//     cnt != 0 -> cnt--.
//     cnt == 0 -> GAP, cnt <= HIGH_CYCLES-1, pulse_n[i] returns high on that edge.
//     Net result: the low time is exactly LOW_CYCLES cycles.
//   GAP: pulse_n[i]=1.
//     cnt != 0 -> cnt--.
//     cnt == 0 -> compute start = pending | trigger[i].
//       start=1: -> ACTIVE, cnt <= LOW_CYCLES-1, pending <= pending & trigger[i].
//       start=0: -> IDLE.
//   Requests while ACTIVE or GAP (excluding the final GAP cycle, which is covered above):
//     pending==0: pending <= 1.
//     pending==1: request discarded, dropped[i] <= 1 for one cycle.
//   Queue depth is therefore 1 request in flight plus 1 pending; never more.
//   busy[i] = registered (next_state != IDLE).
//     busy rises together with pulse_n[i] falling.
//     busy falls on the edge where the channel enters IDLE.
//   dropped[i] is 0 in every cycle with no overflow.
//   Simultaneous triggers on several channels are all accepted in the same cycle.
//   Reset mid-pulse: pulse_n forced high asynchronously; pending requests are lost and are not
//     reported on dropped.
//   pulse_n never glitches, including across channel start/stop and reset release.
//   Parameter violations (LOW_CYCLES or HIGH_CYCLES < 1) are caught by an elaboration-time
//     $error.
// TESTING
//   T1 reset: assert reset mid-run -> pulse_n=7'h7F, busy=0, dropped=0 immediately; hold 3
//      cycles after release with no trigger -> outputs unchanged.
//   T2 single pulse (LOW=4, HIGH=2): trigger[0]=1 at cycle 0 -> pulse_n[0]=0 cycles 1-4,
//      =1 from cycle 5; busy[0]=1 cycles 1-6; other channels stay 1.
//   T3 queued request: trigger[2] at cycles 0 and 2 -> low 1-4, high 5-6, low 7-10, high
//      11-12, IDLE at 13; dropped[2] stays 0.
//   T4 overflow: trigger[3] at cycles 0, 1, 2 -> exactly two pulses; dropped[3]=1 in cycle 3
//      only.
//   T5 all channels: trigger=7'h7F at cycle 0 -> pulse_n=7'h00 cycles 1-4, then 7'h7F.
//   T6 loopback: pulse_n -> synchronizing falling-edge detector on the same clk, random
//      triggers for 10k cycles -> detected edge count == accepted requests (sent - dropped).

Source files
------------

// File: rtl/falling_edge_generator.sv
// N-channel active-low pulse generator with guaranteed low and recovery times.
// Each channel accepts one request in flight plus one pending; further requests are flagged on dropped.
module falling_edge_generator #(
  parameter int N           = 7,
  parameter int LOW_CYCLES  = 4,
  parameter int HIGH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] trigger,
  output logic [N-1:0] pulse_n,
  output logic [N-1:0] busy,
  output logic [N-1:0] dropped
);

  localparam int MAX_CYCLES = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  if (LOW_CYCLES < 1 || HIGH_CYCLES < 1) begin : g_param_check
    $error("falling_edge_generator: LOW_CYCLES and HIGH_CYCLES must both be >= 1");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          pulse_q;
    logic          busy_q;
    logic          dropped_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state     <= IDLE;
        cnt       <= '0;
        pending   <= 1'b0;
        pulse_q   <= 1'b1;
        busy_q    <= 1'b0;
        dropped_q <= 1'b0;
      end else begin
        dropped_q <= 1'b0;
        unique case (state)
          IDLE: begin
            if (trigger[i]) begin
              state   <= ACTIVE;
              cnt     <= LOW_LOAD;
              pulse_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end

          ACTIVE: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state   <= GAP;
              cnt     <= HIGH_LOAD;
              pulse_q <= 1'b1;
            end
            if (trigger[i]) begin
              if (pending) dropped_q <= 1'b1;
              else         pending   <= 1'b1;
            end
          end

          GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
              if (trigger[i]) begin
                if (pending) dropped_q <= 1'b1;
                else         pending   <= 1'b1;
              end
            end else if (pending || trigger[i]) begin
              // On the last gap cycle a fresh trigger replaces the consumed pending request.
              state   <= ACTIVE;
              cnt     <= LOW_LOAD;
              pulse_q <= 1'b0;
              pending <= pending & trigger[i];
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end

          default: begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            pulse_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign pulse_n[i] = pulse_q;
    assign busy[i]    = busy_q;
    assign dropped[i] = dropped_q;
  end

endmodule

// File: tb/tb_falling_edge_generator.sv
// Directed checks of falling_edge_generator (N=7, LOW=4, HIGH=2) plus a randomized loopback
// through a 2-flop synchronizing falling-edge detector.
module tb_falling_edge_generator;
  localparam int N = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] trigger;
  logic [N-1:0] pulse_n;
  logic [N-1:0] busy;
  logic [N-1:0] dropped;

  int n_assert = 0;
  int n_fail   = 0;

  falling_edge_generator #(
    .N          (N),
    .LOW_CYCLES (4),
    .HIGH_CYCLES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .trigger(trigger),
    .pulse_n(pulse_n),
    .busy   (busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Far-side synchronizer and falling-edge counter
  logic [N-1:0] s1 = '1;
  logic [N-1:0] s2 = '1;
  logic         lb_on = 1'b0;
  int           edges [N];

  initial for (int i = 0; i < N; i++) edges[i] = 0;

  always @(posedge clk) begin
    s1 <= pulse_n;
    s2 <= s1;
    for (int i = 0; i < N; i++)
      if (lb_on && s2[i] && !s1[i]) edges[i] <= edges[i] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int sent [N];
  int lost [N];

  initial begin
    reset   = 1'b1;
    trigger = '0;
    tick();
    tick();
    chk("reset pulse_n", pulse_n, 7'h7F);
    chk("reset busy",    busy,    7'h00);
    chk("reset dropped", dropped, 7'h00);
    reset = 1'b0;
    tick();

    // T2: single pulse on channel 0
    for (int c = 0; c <= 9; c++) begin
      chk($sformatf("T2 pulse_n c%0d", c), pulse_n, (c >= 1 && c <= 4) ? 7'h7E : 7'h7F);
      chk($sformatf("T2 busy c%0d", c),    busy,    (c >= 1 && c <= 6) ? 7'h01 : 7'h00);
      chk($sformatf("T2 dropped c%0d", c), dropped, 7'h00);
      trigger = (c == 0) ? 7'h01 : 7'h00;
      tick();
    end

    // T3: queued request on channel 2
    for (int c = 0; c <= 15; c++) begin
      chk($sformatf("T3 pulse_n c%0d", c), pulse_n,
          ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) ? 7'h7B : 7'h7F);
      chk($sformatf("T3 busy c%0d", c),    busy,    (c >= 1 && c <= 12) ? 7'h04 : 7'h00);
      chk($sformatf("T3 dropped c%0d", c), dropped, 7'h00);
      trigger = (c == 0 || c == 2) ? 7'h04 : 7'h00;
      tick();
    end

    // T4: overflow on channel 3
    for (int c = 0; c <= 15; c++) begin
      chk($sformatf("T4 pulse_n c%0d", c), pulse_n,
          ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)) ? 7'h77 : 7'h7F);
      chk($sformatf("T4 busy c%0d", c),    busy,    (c >= 1 && c <= 12) ? 7'h08 : 7'h00);
      chk($sformatf("T4 dropped c%0d", c), dropped, (c == 3) ? 7'h08 : 7'h00);
      trigger = (c <= 2) ? 7'h08 : 7'h00;
      tick();
    end

    // Trigger on the final gap cycle while a request is pending: both are served
    for (int c = 0; c <= 21; c++) begin
      chk($sformatf("GAPEND pulse_n c%0d", c), pulse_n,
          ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)) ? 7'h7D : 7'h7F);
      chk($sformatf("GAPEND busy c%0d", c),    busy,    (c >= 1 && c <= 18) ? 7'h02 : 7'h00);
      chk($sformatf("GAPEND dropped c%0d", c), dropped, 7'h00);
      trigger = (c == 0 || c == 2 || c == 6) ? 7'h02 : 7'h00;
      tick();
    end

    // T5: all channels at once
    for (int c = 0; c <= 8; c++) begin
      chk($sformatf("T5 pulse_n c%0d", c), pulse_n, (c >= 1 && c <= 4) ? 7'h00 : 7'h7F);
      chk($sformatf("T5 busy c%0d", c),    busy,    (c >= 1 && c <= 6) ? 7'h7F : 7'h00);
      trigger = (c == 0) ? 7'h7F : 7'h00;
      tick();
    end

    // T1: reset mid-pulse with a pending request, then quiet after release
    trigger = 7'h7F;
    tick();
    chk("T1 pre pulse_n", pulse_n, 7'h00);
    tick();
    trigger = '0;
    reset   = 1'b1;
    #1;
    chk("T1 async pulse_n", pulse_n, 7'h7F);
    chk("T1 async busy",    busy,    7'h00);
    chk("T1 async dropped", dropped, 7'h00);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("T1 post pulse_n c%0d", c), pulse_n, 7'h7F);
      chk($sformatf("T1 post busy c%0d", c),    busy,    7'h00);
      chk($sformatf("T1 post dropped c%0d", c), dropped, 7'h00);
      tick();
    end

    // T6: random loopback
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      lost[i] = 0;
    end
    lb_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) if (dropped[i]) lost[i]++;
      for (int i = 0; i < N; i++) begin
        trigger[i] = ($urandom_range(0, 3) == 0);
        if (trigger[i]) sent[i]++;
      end
      tick();
    end
    trigger = '0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) if (dropped[i]) lost[i]++;
      tick();
    end
    lb_on = 1'b0;
    chk("T6 idle pulse_n", pulse_n, 7'h7F);
    for (int i = 0; i < N; i++)
      chk_int($sformatf("T6 edges ch%0d", i), edges[i], sent[i] - lost[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
